// File: rtl/sdram_wr_burst_feeder.sv
// Write-side feeder for the SDRAM controller. Packs a 16-bit pixel stream into
// 512-word lines held in a 1024-word ping-pong buffer. Each full line is sent as
// one full-page write burst. The {row,bank} address advances once per burst and
// returns to BASE_ADDR at every frame boundary.
module sdram_wr_burst_feeder #(
  parameter int          FRAME_BURSTS = 600,
  parameter logic [14:0] BASE_ADDR    = 15'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic        ready,
  input  logic        f2s_data_valid,
  output logic        rw,
  output logic        rw_en,
  output logic [14:0] f_addr,
  output logic [15:0] f2s_data,
  output logic        overflow,
  output logic        frame_done
);

  // Full-page mode fixes the burst length, so it is not a parameter.
  localparam int          BURST_LEN = 512;
  localparam logic [8:0]  LAST_WORD = 9'(BURST_LEN - 1);
  localparam logic [14:0] LAST_ADDR = BASE_ADDR + 15'(FRAME_BURSTS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_STREAM} state_t;

  state_t      state_q, state_d;
  logic [9:0]  wp_q, wp_d;          // write pointer; bit 9 selects the half
  logic [9:0]  rp_q, rp_d;          // read pointer of the word held in data_q
  logic [14:0] addr_q, addr_d;      // {row,bank} of the next burst
  logic [1:0]  full_q, full_d;      // one flag per half
  logic [1:0]  pend_q, pend_d;      // bursts still owed to the old frame
  logic [15:0] data_q, data_d;      // registered burst word
  logic        overflow_q, overflow_d;
  logic        done_q, done_d;

  logic [15:0] ram [1024];
  logic        ram_we;
  logic [9:0]  ram_wa;
  logic [9:0]  wr_ptr;
  logic [9:0]  rd_next;
  logic [1:0]  clr;
  logic [1:0]  still_full;
  logic        burst_end;

  // Next-state logic: buffer fill, burst FSM, address and frame bookkeeping.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latch can be inferred.
    state_d    = state_q;
    wp_d       = wp_q;
    rp_d       = rp_q;
    addr_d     = addr_q;
    full_d     = full_q;
    pend_d     = pend_q;
    data_d     = data_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    ram_we     = 1'b0;
    rw_en      = 1'b0;
    clr        = 2'b00;
    burst_end  = 1'b0;
    rd_next    = rp_q + 10'd1;

    // A frame start discards the partial line. A coincident pixel becomes word 0.
    wr_ptr = frame_start ? {wp_q[9], 9'd0} : wp_q;
    ram_wa = wr_ptr;
    wp_d   = wr_ptr;
    if (pix_valid) begin
      if (full_q[wr_ptr[9]]) begin
        overflow_d = 1'b1;
      end else begin
        ram_we = 1'b1;
        wp_d   = wr_ptr + 10'd1;
        if (wr_ptr[8:0] == LAST_WORD) full_d[wr_ptr[9]] = 1'b1;
      end
    end

    // Burst FSM. data_q always holds RAM[rp_q] while a line is being sent.
    case (state_q)
      S_IDLE: begin
        if (full_q[rp_q[9]]) begin
          data_d  = ram[rp_q];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (ready) begin
          rw_en   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT, S_STREAM: begin
        if (f2s_data_valid) begin
          rp_d = rd_next;
          if (rp_q[8:0] == LAST_WORD) begin
            burst_end     = 1'b1;
            clr[rp_q[9]]  = 1'b1;
            state_d       = S_IDLE;
          end else begin
            data_d  = ram[rd_next];
            state_d = S_STREAM;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    full_d = full_d & ~clr;

    // Address step. The last burst of the old frame resets the address to BASE_ADDR.
    if (burst_end) begin
      if (addr_q == LAST_ADDR) begin
        done_d = 1'b1;
        addr_d = BASE_ADDR;
      end else if (pend_q == 2'd1) begin
        addr_d = BASE_ADDR;
      end else begin
        addr_d = addr_q + 15'd1;
      end
      if (pend_q != 2'd0) pend_d = pend_q - 2'd1;
    end

    // Lines already complete at frame start still use the old frame's addresses.
    still_full = full_q & ~clr;
    if (frame_start) begin
      pend_d = {1'b0, still_full[0]} + {1'b0, still_full[1]};
      if (still_full == 2'b00) addr_d = BASE_ADDR;
    end
  end

  // State registers with synchronous reset; a burst in flight is abandoned.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= S_IDLE;
      wp_q       <= '0;
      rp_q       <= '0;
      addr_q     <= BASE_ADDR;
      full_q     <= '0;
      pend_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      addr_q     <= addr_d;
      full_q     <= full_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  // Line buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the RAM has no reset; the half flags decide which contents are valid.
    if (ram_we) ram[ram_wa] <= pix_data;
  end

  assign rw         = 1'b0;
  assign f_addr     = addr_q;
  assign f2s_data   = data_q;
  assign overflow   = overflow_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_sdram_wr_burst_feeder.sv
// Bench for sdram_wr_burst_feeder. Stimulus pushes the expected burst addresses
// and words into queues. A monitor pops them whenever rw_en or f2s_data_valid
// is seen. A small controller model answers each rw_en with 512 back-to-back strobes.
module tb_sdram_wr_burst_feeder;

  logic        clk;
  logic        rst;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        frame_start;
  logic        ready;
  logic        f2s_data_valid;
  logic        rw;
  logic        rw_en;
  logic [14:0] f_addr;
  logic [15:0] f2s_data;
  logic        overflow;
  logic        frame_done;

  sdram_wr_burst_feeder #(
    .FRAME_BURSTS(3),
    .BASE_ADDR   (15'd0)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pix_data      (pix_data),
    .pix_valid     (pix_valid),
    .frame_start   (frame_start),
    .ready         (ready),
    .f2s_data_valid(f2s_data_valid),
    .rw            (rw),
    .rw_en         (rw_en),
    .f_addr        (f_addr),
    .f2s_data      (f2s_data),
    .overflow      (overflow),
    .frame_done    (frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_data[$];
  logic [14:0] exp_addr[$];
  int          rw_cnt, done_cnt, strobe_cnt, bursts_done, in_burst;
  bit          ctrl_busy;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sb();
    exp_data.delete();
    exp_addr.delete();
    rw_cnt      = 0;
    done_cnt    = 0;
    strobe_cnt  = 0;
    bursts_done = 0;
    in_burst    = 0;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    repeat (3) tick();
    clear_sb();
    rst = 1'b0;
  endtask

  task automatic send_line(input logic [15:0] base, input int n, input bit push);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_data  = base + 16'(i);
      if (push) exp_data.push_back(pix_data);
      tick();
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_data.size() != 0 || exp_addr.size() != 0 || ctrl_busy) && n < budget) begin
      tick();
      n++;
    end
    check(name, exp_data.size() + exp_addr.size(), 0);
    repeat (4) tick();
  endtask

  // Monitor: compares every request and every strobed word against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rw_en) begin
          rw_cnt++;
          check("rw_en_ready", int'(ready), 1);
          check("rw_const", int'(rw), 0);
          if (exp_addr.size() == 0) check("rw_en_unexpected", 1, 0);
          else check("f_addr", int'(f_addr), int'(exp_addr.pop_front()));
        end
        if (f2s_data_valid) begin
          strobe_cnt++;
          if (exp_data.size() == 0) check("strobe_unexpected", 1, 0);
          else check("f2s_data", int'(f2s_data), int'(exp_data.pop_front()));
          in_burst++;
          if (in_burst == 512) begin
            in_burst = 0;
            bursts_done++;
          end
        end
        if (frame_done) begin
          done_cnt++;
          check("frame_done_pos", bursts_done % 3, 0);
        end
      end
    end
  end

  // Controller model: a short latency after rw_en, then 512 consecutive strobes.
  initial begin
    f2s_data_valid = 1'b0;
    ctrl_busy      = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && rw_en) begin
        ctrl_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if (!rst) begin
          f2s_data_valid = 1'b1;
          for (int i = 0; i < 512; i++) begin
            @(posedge clk);
            #1;
            if (rst) break;
          end
        end
        f2s_data_valid = 1'b0;
        ctrl_busy      = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    pix_data    = '0;
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    ready       = 1'b0;
    rst         = 1'b1;
    clear_sb();

    // Reset state and a single line.
    do_reset();
    check("rst_rw_en", int'(rw_en), 0);
    check("rst_rw", int'(rw), 0);
    check("rst_f_addr", int'(f_addr), 0);
    check("rst_f2s_data", int'(f2s_data), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_frame_done", int'(frame_done), 0);
    ready = 1'b1;
    exp_addr.push_back(15'd0);
    send_line(16'h0000, 512, 1'b1);
    wait_drain("t1_drain", 2000);
    check("t1_rw_cnt", rw_cnt, 1);
    repeat (20) tick();
    check("t1_no_extra_req", rw_cnt, 1);
    check("t1_overflow", int'(overflow), 0);

    // Two lines fill while the controller is busy.
    do_reset();
    ready = 1'b0;
    send_line(16'h1000, 1024, 1'b1);
    repeat (50) tick();
    check("t2_no_req_busy", rw_cnt, 0);
    check("t2_overflow", int'(overflow), 0);
    exp_addr.push_back(15'd0);
    exp_addr.push_back(15'd1);
    ready = 1'b1;
    wait_drain("t2_drain", 3000);
    check("t2_rw_cnt", rw_cnt, 2);

    // Overflow: dropped pixel, sticky flag, write pointer holds.
    do_reset();
    ready = 1'b0;
    exp_addr.push_back(15'd0);
    exp_addr.push_back(15'd1);
    send_line(16'h2000, 1024, 1'b1);
    send_line(16'hDEAD, 1, 1'b0);
    check("t3_overflow_set", int'(overflow), 1);
    repeat (10) tick();
    check("t3_overflow_hold", int'(overflow), 1);
    ready = 1'b1;
    wait_drain("t3_drain", 3000);
    check("t3_overflow_sticky", int'(overflow), 1);
    exp_addr.push_back(15'd2);
    send_line(16'h3000, 512, 1'b1);
    wait_drain("t3_drain2", 2000);
    check("t3_done_cnt", done_cnt, 1);

    // Frame wrap with three bursts per frame.
    do_reset();
    ready = 1'b1;
    exp_addr.push_back(15'd0);
    exp_addr.push_back(15'd1);
    exp_addr.push_back(15'd2);
    exp_addr.push_back(15'd0);
    for (int l = 0; l < 4; l++) begin
      send_line(16'h4000 + 16'(l * 512), 512, 1'b1);
      repeat (20) tick();
    end
    wait_drain("t4_drain", 3000);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_rw_cnt", rw_cnt, 4);
    check("t4_overflow", int'(overflow), 0);

    // frame_start discards a partial line and restarts the address.
    do_reset();
    ready = 1'b1;
    exp_addr.push_back(15'd0);
    send_line(16'h5000, 512, 1'b1);
    wait_drain("t5_drain1", 2000);
    exp_addr.push_back(15'd0);
    send_line(16'h7000, 300, 1'b0);
    frame_start = 1'b1;
    pix_valid   = 1'b1;
    pix_data    = 16'hBEEF;
    exp_data.push_back(16'hBEEF);
    tick();
    frame_start = 1'b0;
    send_line(16'h6001, 511, 1'b1);
    wait_drain("t5_drain2", 2000);
    check("t5_rw_cnt", rw_cnt, 2);
    check("t5_overflow", int'(overflow), 0);

    // Reset in the middle of a burst.
    do_reset();
    ready = 1'b0;
    exp_addr.push_back(15'd0);
    send_line(16'h8000, 1024, 1'b1);
    send_line(16'hDEAD, 1, 1'b0);
    check("t6_overflow_pre", int'(overflow), 1);
    ready = 1'b1;
    n = 0;
    while (strobe_cnt < 200 && n < 3000) begin
      tick();
      n++;
    end
    check("t6_reach_word_200", int'(strobe_cnt >= 200), 1);
    rst = 1'b1;
    tick();
    check("t6_rw_en", int'(rw_en), 0);
    check("t6_overflow", int'(overflow), 0);
    check("t6_frame_done", int'(frame_done), 0);
    check("t6_f2s_data", int'(f2s_data), 0);
    check("t6_f_addr", int'(f_addr), 0);
    repeat (2) tick();
    clear_sb();
    rst = 1'b0;
    repeat (40) tick();
    check("t6_buffer_empty", rw_cnt, 0);
    check("t6_overflow_after", int'(overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_wr_burst_feeder.md
Name: sdram_wr_burst_feeder

Overview:
- Write-side feeder directly upstream of the SDRAM controller.
- Accepts a 16-bit pixel stream (RGB565 or Sobel output) in the 143 MHz controller domain and packs it into 512-word lines in a ping-pong buffer.
- Requests full-page write bursts (rw=0) through the controller's rw_en/ready handshake.
- Streams each line on the controller's f2s_data_valid strobe, advancing the {row,bank} address per burst across one frame.

Parameters:
BURST_LEN, 512, words per burst; fixed by full-page mode, not to be overridden.
FRAME_BURSTS, 600, bursts per frame (640x480 pixels / 512).
BASE_ADDR, 15'd0, f_addr of the first burst of every frame.

Ports:
clk  in  1  controller clock, 143 MHz
rst  in  1  synchronous active-high reset
pix_data  in  16  pixel word
pix_valid  in  1  pix_data is valid this cycle
frame_start  in  1  one-cycle pulse at the start of a frame (synchronised vsync)
ready  in  1  controller idle and accepting requests
f2s_data_valid  in  1  controller consumes f2s_data this cycle
rw  out  1  constant 0 (write)
rw_en  out  1  one-cycle burst request
f_addr  out  15  [14:2] row, [1:0] bank
f2s_data  out  16  current burst word, registered
overflow  out  1  sticky: pixel dropped because both halves were full
frame_done  out  1  one-cycle pulse after the last burst of a frame completes

Behaviour:
- Reset: all outputs 0. Pointers, address counter, half flags, sticky overflow and FSM (IDLE) all cleared. rst is asserted together with the controller reset; any burst in flight is abandoned.
- Buffer: 1024x16 RAM split into half A (0-511) and half B (512-1023).
  - Write pointer wp[9:0] increments on each pix_valid and wraps 1023->0.
  - When wp crosses 511->512 or 1023->0, that half's full flag sets.
- Overflow: pix_valid while the target half is still full (not yet drained) -> pixel dropped, wp holds, overflow sets. overflow clears only on rst.
- Prefetch: rp[9:0] plus registered output f2s_data, preloaded with RAM[rp] before rw_en is issued.
  - The controller samples f2s_data in the same cycle f2s_data_valid=1.
  - Each cycle with f2s_data_valid=1 loads f2s_data with the next word by the following edge (zero bubbles).
- FSM states: IDLE, REQ, WAIT, STREAM.
  - IDLE: if the half at rp is full -> prefetch word 0 -> REQ.
  - REQ: when ready=1, drive rw_en=1 for exactly one cycle with f_addr=addr_cnt and rw=0 -> WAIT. rw_en is never asserted while ready=0.
  - WAIT: hold until the first f2s_data_valid -> STREAM. That first strobe counts as word 0.
  - STREAM: count strobes. On the 512th strobe: clear that half's full flag, rp wraps to the other half, addr_cnt increments -> IDLE.
  - If addr_cnt reaches BASE_ADDR+FRAME_BURSTS-1 and that burst completes: frame_done pulses one cycle and addr_cnt returns to BASE_ADDR.
- Address arithmetic: addr_cnt is 15 bits and increments by 1, so consecutive bursts rotate banks 0..3 before the row increments. Wrap to BASE_ADDR only at the frame boundary, never at 2^15.
- frame_start:
  - wp snaps back to the base of its current fill half, discarding the partial line.
  - Next idle addr_cnt = BASE_ADDR; already-full halves are still written before the address reset takes effect.
  - A burst in REQ/WAIT/STREAM completes untouched.
  - A pix_valid in the same cycle as frame_start is written as word 0 of the new frame.
- Words are written in arrival order; words after the 512th strobe are never presented.

Test Plan:
- Reset then 512 pixels 0x0000..0x01FF with ready=1 and the controller model strobing 512 cycles -> exactly one rw_en pulse, f_addr=0, rw=0. f2s_data equals 0x0000..0x01FF on successive strobes with no gaps. Half A flag clears.
- 1024 back-to-back pixels while ready is held 0 for 600 cycles -> no overflow, no rw_en until ready rises. Then two bursts at f_addr=0 and then 1.
- 1025th pixel while both halves are full and ready=0 -> overflow=1 and stays 1. Remaining data intact. wp unchanged on the dropped pixel.
- FRAME_BURSTS=3 override, 1536 pixels -> f_addr sequence 0,1,2. frame_done pulses once after the 3rd burst. The next burst uses f_addr=0.
- 300 pixels then frame_start with a simultaneous pixel 0xBEEF, then 511 more -> the first burst starts with word 0xBEEF at f_addr=BASE_ADDR. The 300 pixels are never written.
- rst asserted mid-STREAM (word 200) -> next cycle rw_en=0, overflow=0, frame_done=0, FSM in IDLE, buffer reported empty.
